// File: rtl/ext_pipe.sv
// ext_pipe -- pipelined immediate / load-data extension unit.
//
// Computes one of eight extension modes on an accepted request, registers the
// result (and its misalignment flag) for one cycle, and hands it downstream
// over a valid/ready handshake. A one-entry skid buffer keeps in_ready a pure
// register decode so producer and consumer can stall independently.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous discard of held and same-cycle incoming work
//   in_valid   request present          in_ready   unit can accept (!skid full)
//   ExtOp      extension mode (0..7)    In         immediate or raw load word
//   Addr       byte offset for byte/halfword modes
//   out_valid  Ext/out_err hold a result
//   out_ready  consumer accepts the result
//   Ext        extended result          out_err    misaligned halfword access
module ext_pipe #(
  parameter int  DW = 32,
  parameter int  IW = 16,
  localparam int AW = $clog2(DW / 8)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    ExtOp,
  input  logic [DW-1:0] In,
  input  logic [AW-1:0] Addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Ext,
  output logic          out_err
);

  typedef enum logic [2:0] {
    OP_ZEXT_IMM = 3'd0,
    OP_SEXT_IMM = 3'd1,
    OP_UPPER    = 3'd2,
    OP_SEXT_B   = 3'd3,
    OP_ZEXT_B   = 3'd4,
    OP_SEXT_H   = 3'd5,
    OP_ZEXT_H   = 3'd6,
    OP_PASS     = 3'd7
  } op_e;

  // Occupancy of the two slots: output register and skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e state_q, state_d;

  logic [DW-1:0] ext_q, skid_ext_q, new_ext;
  logic          err_q, skid_err_q, new_err;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          accept, pop;
  logic          load_out, load_skid, skid_to_out;

  // ---------------------------------------------------------------------------
  // Extension datapath (evaluated only at acceptance; result is then held)
  // ---------------------------------------------------------------------------
  // Little-endian lane select; the halfword lane ignores Addr[0] so that a
  // misaligned access still returns the containing aligned halfword.
  assign sel_byte = In[{Addr, 3'b000} +: 8];
  assign sel_half = In[{Addr[AW-1:1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    new_ext = '0;
    new_err = 1'b0;
    unique case (op_e'(ExtOp))
      OP_ZEXT_IMM: new_ext = {{(DW-IW){1'b0}}, In[IW-1:0]};
      OP_SEXT_IMM: new_ext = {{(DW-IW){In[IW-1]}}, In[IW-1:0]};
      OP_UPPER:    new_ext = {In[IW-1:0], {(DW-IW){1'b0}}};
      OP_SEXT_B:   new_ext = {{(DW-8){sel_byte[7]}}, sel_byte};
      OP_ZEXT_B:   new_ext = {{(DW-8){1'b0}}, sel_byte};
      OP_SEXT_H: begin
        new_ext = {{(DW-16){sel_half[15]}}, sel_half};
        new_err = Addr[0];
      end
      OP_ZEXT_H: begin
        new_ext = {{(DW-16){1'b0}}, sel_half};
        new_err = Addr[0];
      end
      OP_PASS:     new_ext = In;
      default:     new_ext = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Occupancy control
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            load_out = 1'b1;
          end else if (accept) begin
            // Consumer stalled: keep the output stable, park the new result.
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d     = ONE;
          skid_to_out = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: data registers are reset as well as the valid bits, because Ext and
    // out_err must read zero immediately on reset, not only once a valid arrives.
    if (reset) begin
      ext_q      <= '0;
      err_q      <= 1'b0;
      skid_ext_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (load_out) begin
        ext_q <= new_ext;
        err_q <= new_err;
      end else if (skid_to_out) begin
        ext_q <= skid_ext_q;
        err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_ext_q <= new_ext;
        skid_err_q <= new_err;
      end
    end
  end

  assign Ext     = ext_q;
  assign out_err = err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe (DW=32, IW=16): directed vector table,
// hand-written backpressure / flush / async-reset sequences, and randomized
// traffic compared every cycle against a queue-based reference model.
module tb_ext_pipe;

  localparam int DW = 32;
  localparam int IW = 16;

  typedef struct {
    logic [31:0] ext;
    logic        err;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] din;
    logic [1:0]  addr;
    logic [31:0] exp_ext;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ExtOp;
  logic [31:0] In;
  logic [1:0]  Addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Ext;
  logic        out_err;

  int n_checks = 0;
  int n_errors = 0;

  res_t mq[$];   // reference model: results held by the unit, oldest first
  vec_t vecs[12];

  ext_pipe #(.DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ExtOp     (ExtOp),
    .In        (In),
    .Addr      (Addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Ext       (Ext),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference extension computed with plain integer arithmetic.
  function automatic res_t ref_ext(input int op, input logic [31:0] x, input int addr);
    res_t   r;
    longint xv, imm, b, h, v;
    xv  = longint'(x);
    imm = xv % 65536;
    b   = (xv / (longint'(1) << (8 * addr))) % 256;
    h   = (xv / (longint'(1) << (16 * (addr / 2)))) % 65536;
    case (op)
      0:       v = imm;
      1:       v = (imm >= 32768) ? imm - 65536 : imm;
      2:       v = imm * 65536;
      3:       v = (b >= 128) ? b - 256 : b;
      4:       v = b;
      5:       v = (h >= 32768) ? h - 65536 : h;
      6:       v = h;
      default: v = xv;
    endcase
    r.ext = v[31:0];
    r.err = (op == 5 || op == 6) && (addr % 2 == 1);
    return r;
  endfunction

  // One clock edge of the model: results leave from the front when the
  // consumer takes one, new requests join the back while fewer than two are held.
  task automatic model_step();
    bit can_take;
    if (flush) begin
      mq.delete();
    end else begin
      can_take = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (can_take) mq.push_back(ref_ext(int'(ExtOp), In, int'(Addr)));
    end
  endtask

  task automatic compare_model();
    check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      check("Ext", 64'(Ext), 64'(mq[0].ext));
      check("out_err", 64'(out_err), 64'(mq[0].err));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d,
                       input logic [1:0] a, input logic ordy, input logic fl);
    in_valid  = v;
    ExtOp     = op;
    In        = d;
    Addr      = a;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0};
    vecs[1]  = '{3'd0, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0};
    vecs[2]  = '{3'd2, 32'h0000_1234, 2'd0, 32'h1234_0000, 1'b0};
    vecs[3]  = '{3'd3, 32'h1234_8078, 2'd1, 32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{3'd4, 32'h1234_8078, 2'd1, 32'h0000_0080, 1'b0};
    vecs[5]  = '{3'd7, 32'h1234_8078, 2'd1, 32'h1234_8078, 1'b0};
    vecs[6]  = '{3'd5, 32'h1234_8078, 2'd3, 32'h0000_1234, 1'b1};
    vecs[7]  = '{3'd5, 32'h1234_8078, 2'd0, 32'hFFFF_8078, 1'b0};
    vecs[8]  = '{3'd6, 32'h1234_8078, 2'd2, 32'h0000_1234, 1'b0};
    vecs[9]  = '{3'd6, 32'h1234_8078, 2'd1, 32'h0000_8078, 1'b1};
    vecs[10] = '{3'd3, 32'h9234_8078, 2'd3, 32'hFFFF_FF92, 1'b0};
    vecs[11] = '{3'd2, 32'hFFFF_8001, 2'd2, 32'h8001_0000, 1'b0};

    // ---- reset state ----
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b1, 1'b0);
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_Ext", 64'(Ext), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // ---- directed table, back-to-back at full throughput ----
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].din, vecs[i].addr, 1'b1, 1'b0);
      cycle();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_Ext", i), 64'(Ext), 64'(vecs[i].exp_ext));
      check($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].exp_err));
    end
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b1, 1'b0);
    cycle();

    // ---- backpressure: A, B fill both slots, C waits, then drain in order ----
    drive(1'b1, 3'd7, 32'hAAAA_0001, 2'd0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 3'd7, 32'hBBBB_0002, 2'd0, 1'b0, 1'b0);
    cycle();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    drive(1'b1, 3'd7, 32'hCCCC_0003, 2'd0, 1'b0, 1'b0);
    cycle();
    check("bp_hold_A", 64'(Ext), 64'hAAAA_0001);
    check("bp_C_not_taken", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    check("bp_B", 64'(Ext), 64'hBBBB_0002);
    cycle();
    check("bp_C", 64'(Ext), 64'hCCCC_0003);
    check("bp_C_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    cycle();
    check("bp_drained", 64'(out_valid), 64'd0);

    // ---- flush while FULL with a pending request ----
    drive(1'b1, 3'd7, 32'h1111_1111, 2'd0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 3'd7, 32'h2222_2222, 2'd0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 3'd7, 32'h3333_3333, 2'd0, 1'b0, 1'b1);
    cycle();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    // flush also discards an acceptable same-cycle request
    drive(1'b1, 3'd7, 32'h4444_4444, 2'd0, 1'b1, 1'b1);
    cycle();
    check("flush_drop_incoming", 64'(out_valid), 64'd0);
    drive(1'b0, 3'd0, 32'h0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("flush_stays_empty", 64'(out_valid), 64'd0);
    end

    // ---- asynchronous reset while FULL ----
    drive(1'b1, 3'd6, 32'hDEAD_BEEF, 2'd1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 3'd5, 32'hCAFE_F00D, 2'd3, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    mq.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_Ext", 64'(Ext), 64'd0);
    check("arst_out_err", 64'(out_err), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3'd1, 32'h0000_F00F, 2'd0, 1'b1, 1'b0);
    cycle();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_Ext", 64'(Ext), 64'hFFFF_F00F);
    in_valid = 1'b0;
    cycle();

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, pipelined extension unit that generalises the decode-stage immediate extender. It handles zero/sign/upper-half immediate extension and also load-data byte/halfword select-and-extend. It carries a one-cycle registered datapath with a valid/ready handshake and a one-entry skid buffer, so it can sit between pipeline stages that stall independently. It is used in D for immediates and in W for load-result formatting.

## Interface
- DW, 32: data width; 32 or 64.
- IW, 16: immediate width; IW < DW.
- AW, log2(DW/8): byte-address width; derived, not overridden.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all held and incoming work.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; equals !skid_valid.
- ExtOp  in  3  mode, see Operation.
- In  in  DW  immediate (low IW bits) or raw load word.
- Addr  in  AW  byte offset, used by modes 3–6.
- out_valid  out  1  Ext is valid.
- out_ready  in  1  consumer accepts Ext.
- Ext  out  DW  result.
- out_err  out  1  misaligned halfword access flagged with this result.

## Operation
- Modes. Bytes are little-endian: byte k = In[8k+7:8k].
  - 0: zero-extend In[IW-1:0].
  - 1: sign-extend In[IW-1:0].
  - 2: upper placement, In[IW-1:0] << (DW-IW), low bits zero.
  - 3: sign-extend byte Addr.
  - 4: zero-extend byte Addr.
  - 5: sign-extend halfword Addr[AW-1:1].
  - 6: zero-extend halfword Addr[AW-1:1].
  - 7: pass In unchanged.
- out_err=1 only for modes 5/6 with Addr[0]=1. Data is still computed from Addr[AW-1:1]. Every other mode gives out_err=0.
- Result is computed combinationally at acceptance and registered with its out_err. Nothing recomputes after capture.
- Storage is two slots, output register (out_valid) and skid register (skid_valid). Occupancy states:
  - EMPTY (0/0): accept → ONE.
  - ONE (1/0): accept and out_ready → ONE, with new data in the output register. Accept without out_ready → FULL, new data in skid. out_ready without accept → EMPTY.
  - FULL (1/1): out_ready → ONE, skid moves to output. No accept is possible (in_ready=0).
- Order is strictly FIFO. No result is dropped or duplicated outside flush/reset.
- Boundaries:
  - flush=1: next edge clears out_valid and skid_valid. The same-cycle input is discarded even if in_valid && in_ready. flush has priority over every other event.
  - reset: immediately forces out_valid=0, skid_valid=0, Ext=0, out_err=0, skid data=0. in_ready=1 while reset is high. Reset mid-transfer loses held data.
  - ExtOp/In/Addr are ignored when in_valid=0 or in_ready=0.

## Timing
- Latency is 1 cycle: accepted at edge N, visible on Ext/out_valid after edge N.
- Throughput is 1 result/cycle while out_ready=1.
- in_ready is a register-derived signal with no combinational path from in_valid or out_ready. It falls the cycle after FULL is entered and rises the cycle after the skid drains.
- Ext and out_err are stable while out_valid=1 && out_ready=0.
- Transfer occurs on an edge with out_valid && out_ready.
- Reset values: out_valid=0, Ext=0, out_err=0, in_ready=1.

## Test plan
- DW=32, IW=16, out_ready=1. Send mode 1, In=0x0000_8001 → Ext=0xFFFF_8001 one cycle later. Send mode 0, same In → 0x0000_8001. Send mode 2, In=0x0000_1234 → 0x1234_0000.
- Send mode 3, In=0x1234_8078, Addr=1 → 0xFFFF_FF80. Send mode 4, same → 0x0000_0080. Send mode 7 → 0x1234_8078, out_err=0.
- Send mode 5, In=0x1234_8078, Addr=3 → Ext=0x0000_1234, out_err=1. Send mode 5, Addr=0 → 0xFFFF_8078, out_err=0.
- out_ready=0, push A then B. in_ready=0 the cycle after B, and a held C is not accepted. Raise out_ready → A, B, then C on consecutive cycles, no gaps.
- FULL state with in_valid=1 and flush=1 → next cycle out_valid=0, in_ready=1. Nothing from before the flush ever appears.
- Assert reset asynchronously mid-stream while FULL → out_valid, Ext, out_err go to 0 immediately, without waiting for a clock edge. After release the first new request completes with latency 1.
